ntt_butterfly_mlane: RTL and testbench

Multi-lane, mode-selectable radix-2 NTT butterfly over Z_Q with Montgomery reduction. This is the next generation of the single-lane forward butterfly. It adds:
- LANES parallel butterflies per beat;
- per-beat Cooley-Tukey (forward) or Gentleman-Sande (inverse) mode;
- valid/ready backpressure and a pass-through tag;
- a sticky out-of-range flag.

It sits between the NTT coefficient memory read port and the write-back path of the transform engine.

---
 rtl/ntt_butterfly_mlane.sv | 203 ++++++++++++++++++++
 tb/tb_ntt_butterfly_mlane.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_butterfly_mlane.sv
// ntt_butterfly_mlane
//   Multi-lane radix-2 NTT butterfly over Z_Q with Montgomery reduction.
//   Each beat carries LANES independent butterflies. The per-beat mode picks
//   the Cooley-Tukey (forward) or Gentleman-Sande (inverse) form. A beat runs
//   through a four-register pipeline (S1 pre-add/sub, S2 product,
//   S3 Montgomery result, S4 output). All stages share one enable, so
//   backpressure stalls the whole pipe and bubbles are never compressed.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid / in_ready       input handshake
//   in_mode                   0 = CT forward, 1 = GS inverse (whole beat)
//   in_tag                    opaque tag returned with the result
//   coeff_a_i/coeff_b_i       operands, lane k at [k*W +: W]
//   twiddle_i                 per-lane twiddle in Montgomery form
//   out_valid / out_ready     output handshake
//   out_tag, coeff_a_o/b_o    result beat
//   range_err_o               sticky: an accepted a or b operand was >= Q
//
// Handshake: a beat moves on an edge where valid && ready are both 1.
// in_ready is combinational from out_valid and out_ready only; once
// out_valid is 1, the out_* signals hold until the edge with out_ready = 1.

module ntt_butterfly_mlane #(
  parameter int             W         = 32,
  parameter int             LANES     = 2,
  parameter int             TAG_W     = 8,
  parameter logic [W-1:0]   Q         = W'(2013265921),
  parameter logic [W-1:0]   Q_INV_NEG = W'(2013265919)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_mode,
  input  logic [TAG_W-1:0]     in_tag,
  input  logic [LANES*W-1:0]   coeff_a_i,
  input  logic [LANES*W-1:0]   coeff_b_i,
  input  logic [LANES*W-1:0]   twiddle_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [TAG_W-1:0]     out_tag,
  output logic [LANES*W-1:0]   coeff_a_o,
  output logic [LANES*W-1:0]   coeff_b_o,
  output logic                 range_err_o
);

  // Modular add: the sum needs W+1 bits before the conditional subtract.
  function automatic logic [W-1:0] add_q(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, Q}) s = s - {1'b0, Q};
    return s[W-1:0];
  endfunction

  // Modular subtract without a sign bit: add Q first when x < y.
  function automatic logic [W-1:0] sub_q(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] s;
    if (x >= y) s = {1'b0, x} - {1'b0, y};
    else        s = {1'b0, x} + {1'b0, Q} - {1'b0, y};
    return s[W-1:0];
  endfunction

  // Montgomery reduction: t * R^-1 mod Q. The low W bits of t + m*Q are zero
  // by construction of m, so only the shifted-down part is kept.
  function automatic logic [W-1:0] mont(input logic [2*W-1:0] t);
    logic [W-1:0]   m;
    logic [2*W:0]   s;
    logic [W:0]     u;
    m = t[W-1:0] * Q_INV_NEG;
    s = {1'b0, t} + {1'b0, ({{W{1'b0}}, m} * {{W{1'b0}}, Q})};
    u = (W+1)'(s >> W);
    if (u >= {1'b0, Q}) u = u - {1'b0, Q};
    return u[W-1:0];
  endfunction

  // Stage control: valid bits, mode and tag travel with the beat.
  logic             r1_valid, r2_valid, r3_valid, r4_valid;
  logic             r1_mode,  r2_mode,  r3_mode;
  logic [TAG_W-1:0] r1_tag,   r2_tag,   r3_tag,   r4_tag;
  logic             r_range_err;

  // Per-lane datapath registers.
  logic [W-1:0]     r1_a    [LANES];
  logic [W-1:0]     r1_b    [LANES];
  logic [W-1:0]     r1_sum  [LANES];
  logic [W-1:0]     r1_diff [LANES];
  logic [W-1:0]     r1_tw   [LANES];
  logic [2*W-1:0]   r2_prod [LANES];
  logic [W-1:0]     r2_add  [LANES];
  logic [W-1:0]     r3_mont [LANES];
  logic [W-1:0]     r3_add  [LANES];
  logic [W-1:0]     r4_a    [LANES];
  logic [W-1:0]     r4_b    [LANES];

  // Per-lane combinational nets.
  logic [W-1:0]     w_a     [LANES];
  logic [W-1:0]     w_b     [LANES];
  logic [W-1:0]     w_tw    [LANES];
  logic [W-1:0]     w_sum   [LANES];
  logic [W-1:0]     w_diff  [LANES];
  logic [W-1:0]     w_op    [LANES];
  logic [W-1:0]     w_mont  [LANES];
  logic [W-1:0]     w_ra    [LANES];
  logic [W-1:0]     w_rb    [LANES];
  logic             w_oor;
  logic             w_en;

  // One global enable: the pipe moves unless a finished beat is stuck at S4.
  assign w_en     = out_ready || !r4_valid;
  assign in_ready = w_en;

  always_comb begin
    w_oor = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      w_a[k]    = coeff_a_i[k*W +: W];
      w_b[k]    = coeff_b_i[k*W +: W];
      w_tw[k]   = twiddle_i[k*W +: W];
      w_sum[k]  = add_q(w_a[k], w_b[k]);
      w_diff[k] = sub_q(w_a[k], w_b[k]);
      // CT multiplies b by the twiddle, GS multiplies (a - b).
      w_op[k]   = r1_mode ? r1_diff[k] : r1_b[k];
      w_mont[k] = mont(r2_prod[k]);
      if (r3_mode) begin
        w_ra[k] = r3_add[k];
        w_rb[k] = r3_mont[k];
      end else begin
        w_ra[k] = add_q(r3_add[k], r3_mont[k]);
        w_rb[k] = sub_q(r3_add[k], r3_mont[k]);
      end
      if ((w_a[k] >= Q) || (w_b[k] >= Q)) w_oor = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_valid    <= 1'b0;
      r2_valid    <= 1'b0;
      r3_valid    <= 1'b0;
      r4_valid    <= 1'b0;
      r1_mode     <= 1'b0;
      r2_mode     <= 1'b0;
      r3_mode     <= 1'b0;
      r1_tag      <= '0;
      r2_tag      <= '0;
      r3_tag      <= '0;
      r4_tag      <= '0;
      r_range_err <= 1'b0;
      for (int k = 0; k < LANES; k++) begin
        r1_a[k]    <= '0;
        r1_b[k]    <= '0;
        r1_sum[k]  <= '0;
        r1_diff[k] <= '0;
        r1_tw[k]   <= '0;
        r2_prod[k] <= '0;
        r2_add[k]  <= '0;
        r3_mont[k] <= '0;
        r3_add[k]  <= '0;
        r4_a[k]    <= '0;
        r4_b[k]    <= '0;
      end
    end else begin
      if (in_valid && w_en && w_oor) r_range_err <= 1'b1;
      if (w_en) begin
        r1_valid <= in_valid;
        r2_valid <= r1_valid;
        r3_valid <= r2_valid;
        r4_valid <= r3_valid;
        r1_mode  <= in_mode;
        r2_mode  <= r1_mode;
        r3_mode  <= r2_mode;
        r1_tag   <= in_tag;
        r2_tag   <= r1_tag;
        r3_tag   <= r2_tag;
        r4_tag   <= r3_tag;
        for (int k = 0; k < LANES; k++) begin
          r1_a[k]    <= w_a[k];
          r1_b[k]    <= w_b[k];
          r1_sum[k]  <= w_sum[k];
          r1_diff[k] <= w_diff[k];
          r1_tw[k]   <= w_tw[k];
          r2_prod[k] <= {{W{1'b0}}, w_op[k]} * {{W{1'b0}}, r1_tw[k]};
          // The addend that S4 needs: a for CT, the finished a+b for GS.
          r2_add[k]  <= r1_mode ? r1_sum[k] : r1_a[k];
          r3_mont[k] <= w_mont[k];
          r3_add[k]  <= r2_add[k];
          r4_a[k]    <= w_ra[k];
          r4_b[k]    <= w_rb[k];
        end
      end
    end
  end

  assign out_valid   = r4_valid;
  assign out_tag     = r4_tag;
  assign range_err_o = r_range_err;

  for (genvar k = 0; k < LANES; k++) begin : g_out
    assign coeff_a_o[k*W +: W] = r4_a[k];
    assign coeff_b_o[k*W +: W] = r4_b[k];
  end

endmodule

// File: tb/tb_ntt_butterfly_mlane.sv
// Testbench for ntt_butterfly_mlane: directed vector table, backpressure,
// range-flag and mid-stream reset sequences, plus a long randomized
// mixed-mode stream checked against a modular-arithmetic reference model.

module tb_ntt_butterfly_mlane;

  localparam int W     = 32;
  localparam int LANES = 2;
  localparam int TAG_W = 8;
  localparam int LW    = LANES * W;
  localparam int EXPW  = 1 + TAG_W + 2 * LW;   // {dont_care, tag, a_o, b_o}

  localparam logic [W-1:0] QV = 32'd2013265921;
  localparam logic [W-1:0] RQ = 32'd268435454;   // R mod Q (Montgomery one)
  localparam longint unsigned QL = 64'd2013265921;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic              in_mode;
  logic [TAG_W-1:0]  in_tag;
  logic [LW-1:0]     coeff_a_i;
  logic [LW-1:0]     coeff_b_i;
  logic [LW-1:0]     twiddle_i;
  logic              out_valid;
  logic              out_ready;
  logic [TAG_W-1:0]  out_tag;
  logic [LW-1:0]     coeff_a_o;
  logic [LW-1:0]     coeff_b_o;
  logic              range_err_o;

  ntt_butterfly_mlane #(
    .W(W), .LANES(LANES), .TAG_W(TAG_W),
    .Q(32'd2013265921), .Q_INV_NEG(32'd2013265919)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_tag(in_tag),
    .coeff_a_i(coeff_a_i), .coeff_b_i(coeff_b_i), .twiddle_i(twiddle_i),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
    .coeff_a_o(coeff_a_o), .coeff_b_o(coeff_b_o), .range_err_o(range_err_o)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int  errors = 0;
  int  checks = 0;
  bit  mon_en = 1'b0;
  logic [EXPW-1:0] exp_q[$];
  longint unsigned rinv;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint unsigned mulmod(input longint unsigned x, input longint unsigned y);
    return (x * y) % QL;
  endfunction

  function automatic longint unsigned powmod(input longint unsigned base, input longint unsigned e);
    longint unsigned r = 1;
    longint unsigned b = base % QL;
    while (e != 0) begin
      if (e[0]) r = mulmod(r, b);
      b = mulmod(b, b);
      e = e >> 1;
    end
    return r;
  endfunction

  // Butterfly in plain modular arithmetic: the Montgomery-form twiddle is
  // converted to its true value w = tw * R^-1 mod Q.
  function automatic logic [2*LW-1:0] model(input logic mode, input logic [LW-1:0] a,
                                            input logic [LW-1:0] b, input logic [LW-1:0] tw);
    logic [LW-1:0] ao, bo;
    longint unsigned x, y, w, r;
    ao = '0;
    bo = '0;
    for (int k = 0; k < LANES; k++) begin
      x = longint'(a[k*W +: W]);
      y = longint'(b[k*W +: W]);
      w = mulmod(longint'(tw[k*W +: W]) % QL, rinv);
      if (!mode) begin
        r = mulmod(y, w);
        ao[k*W +: W] = W'((x + r) % QL);
        bo[k*W +: W] = W'((x + QL - r) % QL);
      end else begin
        ao[k*W +: W] = W'((x + y) % QL);
        bo[k*W +: W] = W'(mulmod((x + QL - y) % QL, w));
      end
    end
    return {ao, bo};
  endfunction

  // ---------------- driver tasks ----------------
  // Presents one beat from just after a rising edge until it is accepted;
  // returns 1 ns after the accepting edge.
  task automatic send(input logic mode, input logic [TAG_W-1:0] tag, input logic [LW-1:0] a,
                      input logic [LW-1:0] b, input logic [LW-1:0] tw, input bit push, input bit dc);
    bit accepted = 1'b0;
    int cyc = 0;
    in_valid  = 1'b1;
    in_mode   = mode;
    in_tag    = tag;
    coeff_a_i = a;
    coeff_b_i = b;
    twiddle_i = tw;
    while (!accepted && cyc < 200) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1'b1;
        if (push) exp_q.push_back({dc, tag, model(mode, a, b, tw)});
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    if (!accepted) chk("send_timeout", 0, 1);
  endtask

  // Counts edges from the accepting edge (inclusive) until out_valid is seen;
  // returns at the negedge where it is seen.
  task automatic wait_out(output int n);
    n = 1;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
  endtask

  task automatic drain();
    int c = 0;
    while (exp_q.size() != 0 && c < 300) begin
      @(posedge clk);
      c++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
    #1;
  endtask

  function automatic logic [LW-1:0] rand_vec();
    logic [LW-1:0] v;
    for (int k = 0; k < LANES; k++) v[k*W +: W] = $urandom_range(0, 32'd2013265920);
    return v;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EXPW-1:0] e;
    if (!rst && mon_en && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", {out_tag, coeff_a_o, coeff_b_o}, 0);
      end else begin
        e = exp_q.pop_front();
        if (e[EXPW-1]) chk("beat_tag", out_tag, e[EXPW-2 -: TAG_W]);
        else           chk("beat", {out_tag, coeff_a_o, coeff_b_o}, e[EXPW-2:0]);
      end
    end
  end

  // ---------------- directed vector table ----------------
  typedef struct {
    logic         mode;
    logic [W-1:0] tw;
    logic [W-1:0] a0, b0, a1, b1;
    logic [W-1:0] ea0, eb0, ea1, eb1;
  } vec_t;

  vec_t tbl[5];

  // ---------------- main sequence ----------------
  initial begin
    int n;
    bit stale;
    bit done;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_mode   = 1'b0;
    in_tag    = '0;
    coeff_a_i = '0;
    coeff_b_i = '0;
    twiddle_i = '0;
    out_ready = 1'b1;
    rinv      = powmod(64'd268435454, QL - 2);

    tbl[0] = '{mode:1'b0, tw:RQ, a0:5,      b0:3,      a1:1,      b1:3,
               ea0:8,      eb0:2,      ea1:4,      eb1:QV-2};
    tbl[1] = '{mode:1'b1, tw:RQ, a0:QV-1,   b0:2,      a1:5,      b1:3,
               ea0:1,      eb0:QV-3,   ea1:8,      eb1:2};
    tbl[2] = '{mode:1'b0, tw:0,  a0:7,      b0:9,      a1:0,      b1:QV-1,
               ea0:7,      eb0:7,      ea1:0,      eb1:0};
    tbl[3] = '{mode:1'b0, tw:RQ, a0:QV-1,   b0:QV-1,   a1:0,      b1:1,
               ea0:QV-2,   eb0:0,      ea1:1,      eb1:QV-1};
    tbl[4] = '{mode:1'b1, tw:0,  a0:3,      b0:10,     a1:QV-1,   b1:QV-1,
               ea0:13,     eb0:0,      ea1:QV-2,   eb1:0};

    // Reset state.
    #3;
    chk("reset_outputs", {out_valid, out_tag, coeff_a_o, coeff_b_o, range_err_o}, 0);
    chk("reset_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed vectors, one at a time through an empty pipe.
    for (int i = 0; i < 5; i++) begin
      send(tbl[i].mode, TAG_W'(i + 1), {tbl[i].a1, tbl[i].a0}, {tbl[i].b1, tbl[i].b0},
           {tbl[i].tw, tbl[i].tw}, 1'b0, 1'b0);
      wait_out(n);
      chk("vec_latency_edges", n, 4);
      chk("vec_result", {out_tag, coeff_a_o, coeff_b_o},
          {TAG_W'(i + 1), tbl[i].ea1, tbl[i].ea0, tbl[i].eb1, tbl[i].eb0});
      @(posedge clk);
      #1;
    end

    // Back-to-back stream of 10 beats with a 3-cycle stall on the output.
    mon_en = 1'b1;
    fork
      begin
        for (int i = 0; i < 10; i++)
          send(1'($urandom_range(0, 1)), TAG_W'(i), rand_vec(), rand_vec(), rand_vec(), 1'b1, 1'b0);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b0;
        #1;
        chk("stall_out_valid", out_valid, 1);
        chk("stall_in_ready_drop", in_ready, 0);
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          if (exp_q.size() != 0)
            chk("stall_hold", {out_valid, out_tag, coeff_a_o, coeff_b_o}, {1'b1, exp_q[0][EXPW-2:0]});
          else
            chk("stall_queue_nonempty", 0, 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Long mixed-mode random stream with random input gaps and output stalls.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          if ($urandom_range(0, 4) == 0) begin
            @(posedge clk);
            #1;
          end
          send(1'(i % 2), TAG_W'(i), rand_vec(), rand_vec(), rand_vec(), 1'b1, 1'b0);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          if (!done) out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Sticky range flag.
    chk("range_err_clear_before", range_err_o, 0);
    send(1'b0, 8'hA5, rand_vec(), {QV, 32'd7}, {RQ, RQ}, 1'b1, 1'b1);
    chk("range_err_set", range_err_o, 1);
    for (int i = 0; i < 3; i++)
      send(1'(i % 2), TAG_W'(8'hB0 + i), rand_vec(), rand_vec(), rand_vec(), 1'b1, 1'b0);
    drain();
    chk("range_err_sticky", range_err_o, 1);

    // Reset with three beats in flight.
    for (int i = 0; i < 3; i++)
      send(1'(i % 2), TAG_W'(8'hC0 + i), rand_vec(), rand_vec(), rand_vec(), 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    chk("midreset_outputs", {out_valid, out_tag, coeff_a_o, coeff_b_o, range_err_o}, 0);
    chk("midreset_in_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    stale = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    chk("no_stale_after_reset", stale, 0);
    @(posedge clk);
    #1;
    send(1'b0, 8'hD1, rand_vec(), rand_vec(), rand_vec(), 1'b1, 1'b0);
    wait_out(n);
    chk("post_reset_latency_edges", n, 4);
    drain();

    #20;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
